// File: rtl/irq_ctrl.sv
// irq_ctrl: four-source edge-triggered interrupt controller with a memory-mapped register file.
// Define IRQ_CTRL_SYNC_EN to put a two-flop synchronizer on each src line.
module irq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  src,
    input  logic        kernel,
    input  logic        irq_ack,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [31:0] A_IE    = 32'h4000_0030;
    localparam logic [31:0] A_PEND  = 32'h4000_0034;
    localparam logic [31:0] A_CAUSE = 32'h4000_0038;
    localparam logic [31:0] A_CTRL  = 32'h4000_003C;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t     state;
    state_t     state_n;

    logic [3:0] ie;
    logic [3:0] pend;
    logic [3:0] pend_n;
    logic       gie;
    logic       cause_v;
    logic [1:0] cause_id;

    logic [3:0] src_s;
    logic [3:0] src_q;
    logic [3:0] rise;
    logic [3:0] pi;
    logic [1:0] arm_cnt;
    logic       armed;
    logic       take;
    logic [1:0] take_id;

    logic       sel_ie;
    logic       sel_pend;
    logic       sel_cause;
    logic       sel_ctrl;
    logic       unused_wdata;

`ifdef IRQ_CTRL_SYNC_EN
    // Edge detection stays masked until the synchronizer holds real samples.
    localparam logic [1:0] ARM_CYC = 2'd3;

    logic [3:0] sync1;
    logic [3:0] sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= src;
            sync2 <= sync1;
        end
    end

    assign src_s = sync2;
`else
    localparam logic [1:0] ARM_CYC = 2'd1;

    assign src_s = src;
`endif

    assign armed = (arm_cnt == ARM_CYC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q   <= '0;
            arm_cnt <= '0;
        end else begin
            src_q <= src_s;
            if (!armed) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
        end
    end

    assign rise = armed ? (src_s & ~src_q) : 4'b0000;

    assign sel_ie    = (addr == A_IE);
    assign sel_pend  = (addr == A_PEND);
    assign sel_cause = (addr == A_CAUSE);
    assign sel_ctrl  = (addr == A_CTRL);

    assign unused_wdata = ^wdata[31:4];

    assign pi   = pend & ie;
    assign take = (state == REQ) && irq_ack && (|pi);

    always_comb begin
        take_id = 2'd0;
        priority case (1'b1)
            pi[0]:   take_id = 2'd0;
            pi[1]:   take_id = 2'd1;
            pi[2]:   take_id = 2'd2;
            pi[3]:   take_id = 2'd3;
            default: take_id = 2'd0;
        endcase
    end

    // A fresh edge overrides both the W1C and the acknowledge clear.
    always_comb begin
        pend_n = pend;
        if (wr && sel_pend) begin
            pend_n = pend_n & ~wdata[3:0];
        end
        if (take) begin
            pend_n[take_id] = 1'b0;
        end
        pend_n = pend_n | rise;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ie       <= '0;
            pend     <= '0;
            gie      <= 1'b0;
            cause_v  <= 1'b0;
            cause_id <= '0;
        end else begin
            pend <= pend_n;
            if (wr && sel_ie) begin
                ie <= wdata[3:0];
            end
            if (wr && sel_ctrl) begin
                gie <= wdata[0];
            end
            if (take) begin
                cause_v  <= 1'b1;
                cause_id <= take_id;
            end else if (state == SERVICE && !kernel) begin
                cause_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (gie && (|pi) && !kernel) begin
                    state_n = REQ;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_n = (|pi) ? SERVICE : IDLE;
                end else if (!(|pi) || !gie) begin
                    state_n = IDLE;
                end
            end
            SERVICE: begin
                if (!kernel) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        irq = (state == REQ);
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            unique case (1'b1)
                sel_ie:    rdata = {28'h0, ie};
                sel_pend:  rdata = {28'h0, pend};
                sel_cause: rdata = {29'h0, cause_v, cause_id};
                sel_ctrl:  rdata = {31'h0, gie};
                default:   rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Honors IRQ_CTRL_SYNC_EN by shifting the expected source latency.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  src = 4'h0;
    logic        kernel = 1'b0;
    logic        irq_ack = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] rdata;
    logic        irq;

    int total = 0;
    int bad = 0;

`ifdef IRQ_CTRL_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    localparam logic [31:0] A_IE    = 32'h4000_0030;
    localparam logic [31:0] A_PEND  = 32'h4000_0034;
    localparam logic [31:0] A_CAUSE = 32'h4000_0038;
    localparam logic [31:0] A_CTRL  = 32'h4000_003C;
    localparam logic [31:0] A_NONE  = 32'h4000_0040;

    irq_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .src     (src),
        .kernel  (kernel),
        .irq_ack (irq_ack),
        .addr    (addr),
        .wdata   (wdata),
        .rd      (rd),
        .wr      (wr),
        .rdata   (rdata),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = quiet, 1 = requesting, 2 = handler running.
    logic [3:0] m_ie;
    logic [3:0] m_pend;
    logic       m_gie;
    logic       m_cv;
    logic [1:0] m_cid;
    int         m_mode;
    logic [3:0] m_hist[$];
    logic [3:0] m_prev;
    int         m_cyc;

    task automatic model_reset();
        m_ie   = 4'h0;
        m_pend = 4'h0;
        m_gie  = 1'b0;
        m_cv   = 1'b0;
        m_cid  = 2'd0;
        m_mode = 0;
        m_hist.delete();
        m_prev = 4'h0;
        m_cyc  = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a == A_IE)    return {28'h0, m_ie};
        if (a == A_PEND)  return {28'h0, m_pend};
        if (a == A_CAUSE) return {29'h0, m_cv, m_cid};
        if (a == A_CTRL)  return {31'h0, m_gie};
        return 32'h0;
    endfunction

    task automatic model_edge();
        logic [3:0] pi;
        logic [3:0] eff;
        logic [3:0] rise;
        logic [3:0] np;
        int         first;
        int         nmode;
        bit         take;
        pi = m_ie & m_pend;
        first = -1;
        for (int i = 3; i >= 0; i--) if (pi[i]) first = i;
        m_cyc++;
        m_hist.push_back(src);
        eff = (m_hist.size() > LAT) ? m_hist[m_hist.size() - 1 - LAT] : 4'h0;
        rise = (m_cyc > LAT + 1) ? (eff & ~m_prev) : 4'h0;
        m_prev = eff;
        if (m_hist.size() > 8) void'(m_hist.pop_front());
        take = 1'b0;
        nmode = m_mode;
        if (m_mode == 0) begin
            if (m_gie && first >= 0 && !kernel) nmode = 1;
        end else if (m_mode == 1) begin
            if (irq_ack) begin
                if (first >= 0) begin
                    take = 1'b1;
                    nmode = 2;
                end else begin
                    nmode = 0;
                end
            end else if (first < 0 || !m_gie) begin
                nmode = 0;
            end
        end else if (!kernel) begin
            nmode = 0;
            m_cv = 1'b0;
        end
        np = m_pend;
        if (wr && addr == A_PEND) np = np & ~wdata[3:0];
        if (take) begin
            np[first] = 1'b0;
            m_cv = 1'b1;
            m_cid = first[1:0];
        end
        np = np | rise;
        if (wr && addr == A_IE) m_ie = wdata[3:0];
        if (wr && addr == A_CTRL) m_gie = wdata[0];
        m_pend = np;
        m_mode = nmode;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        rd = 1'b1;
        #1;
        d = rdata;
        rd = 1'b0;
        addr = 32'h0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        wdata = d;
        wr = 1'b1;
        tick();
        wr = 1'b0;
        addr = 32'h0;
        wdata = 32'h0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] regs [4];
        regs = '{A_IE, A_PEND, A_CAUSE, A_CTRL};
        reset = 1'b0;
        src = 4'b0010;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_irq got=%b exp=0", irq);
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(regs[i], d);
            total++;
            if (d !== 32'h0) begin
                bad++;
                $display("FAIL reset_reg%0d got=%h exp=0", i, d);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (LAT + 3) tick();
        bus_read(A_PEND, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL release_high_src got=%h exp=0", d);
        end
        src = 4'h0;
        repeat (LAT + 2) tick();
    endtask

    task automatic test_basic();
        logic [31:0] d;
        bus_write(A_IE, 32'hF);
        bus_write(A_CTRL, 32'h1);
        kernel = 1'b0;
        src = 4'h0;
        repeat (LAT + 2) tick();
        src = 4'b0100;
        repeat (LAT + 1) tick();
        bus_read(A_PEND, d);
        total++;
        if (d !== 32'h4) begin
            bad++;
            $display("FAIL basic_pend got=%h exp=%h", d, 32'h4);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL basic_irq_early got=%b exp=0", irq);
        end
        tick();
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL basic_irq_rise got=%b exp=1", irq);
        end
        irq_ack = 1'b1;
        kernel = 1'b1;
        tick();
        irq_ack = 1'b0;
        bus_read(A_CAUSE, d);
        total++;
        if (d !== 32'h6) begin
            bad++;
            $display("FAIL basic_cause got=%h exp=%h", d, 32'h6);
        end
        bus_read(A_PEND, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL basic_pend_clr got=%h exp=0", d);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL basic_irq_drop got=%b exp=0", irq);
        end
        src = 4'h0;
    endtask

    task automatic test_priority();
        logic [31:0] d;
        kernel = 1'b0;
        src = 4'h0;
        repeat (LAT + 2) tick();
        bus_read(A_CAUSE, d);
        total++;
        if (d !== 32'h2) begin
            bad++;
            $display("FAIL prio_cause_cleared got=%h exp=%h", d, 32'h2);
        end
        src = 4'b1010;
        repeat (LAT + 2) tick();
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL prio_irq got=%b exp=1", irq);
        end
        irq_ack = 1'b1;
        kernel = 1'b1;
        tick();
        irq_ack = 1'b0;
        bus_read(A_CAUSE, d);
        total++;
        if (d !== 32'h5) begin
            bad++;
            $display("FAIL prio_cause got=%h exp=%h", d, 32'h5);
        end
        bus_read(A_PEND, d);
        total++;
        if (d !== 32'h8) begin
            bad++;
            $display("FAIL prio_pend got=%h exp=%h", d, 32'h8);
        end
    endtask

    task automatic test_service_return();
        logic [31:0] d;
        kernel = 1'b0;
        tick();
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL ret_irq_idle got=%b exp=0", irq);
        end
        bus_read(A_CAUSE, d);
        total++;
        if (d !== 32'h1) begin
            bad++;
            $display("FAIL ret_cause_valid got=%h exp=%h", d, 32'h1);
        end
        tick();
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL ret_irq_again got=%b exp=1", irq);
        end
        irq_ack = 1'b1;
        kernel = 1'b1;
        tick();
        irq_ack = 1'b0;
        bus_read(A_CAUSE, d);
        total++;
        if (d !== 32'h7) begin
            bad++;
            $display("FAIL ret_cause got=%h exp=%h", d, 32'h7);
        end
        kernel = 1'b0;
        src = 4'h0;
        tick();
    endtask

    task automatic test_w1c_in_req();
        logic [31:0] d;
        repeat (LAT + 2) tick();
        src = 4'b0001;
        repeat (LAT + 2) tick();
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL w1c_irq_req got=%b exp=1", irq);
        end
        bus_write(A_PEND, 32'hF);
        total++;
        if (irq !== (m_mode == 1)) begin
            bad++;
            $display("FAIL w1c_irq_write got=%b exp=%b", irq, m_mode == 1);
        end
        bus_read(A_PEND, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL w1c_pend got=%h exp=0", d);
        end
        tick();
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL w1c_irq_idle got=%b exp=0", irq);
        end
        bus_read(A_CAUSE, d);
        total++;
        if (d !== 32'h3) begin
            bad++;
            $display("FAIL w1c_cause got=%h exp=%h", d, 32'h3);
        end
    endtask

    task automatic test_set_wins();
        logic [31:0] d;
        kernel = 1'b1;
        src = 4'h0;
        repeat (LAT + 2) tick();
        src = 4'b0001;
        repeat (LAT + 1) tick();
        src = 4'h0;
        repeat (LAT + 1) tick();
        src = 4'b0001;
        repeat (LAT) tick();
        bus_write(A_PEND, 32'h1);
        bus_read(A_PEND, d);
        total++;
        if (d !== 32'h1) begin
            bad++;
            $display("FAIL setwins_pend got=%h exp=%h", d, 32'h1);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (irq !== 1'b0) begin
                bad++;
                $display("FAIL kernel_mask_irq%0d got=%b exp=0", i, irq);
            end
        end
        bus_write(A_PEND, 32'h1);
        bus_read(A_PEND, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL plain_w1c got=%h exp=0", d);
        end
        kernel = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] amap [5];
        amap = '{A_IE, A_PEND, A_CAUSE, A_CTRL, A_NONE};
        for (int n = 0; n < 400; n++) begin
            src = 4'($urandom_range(0, 15));
            kernel = ($urandom_range(0, 3) == 0);
            irq_ack = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 7) == 0);
            addr = amap[$urandom_range(0, 4)];
            wdata = $urandom;
            if (addr == A_CTRL) wdata[0] = ($urandom_range(0, 3) != 0);
            tick();
            wr = 1'b0;
            irq_ack = 1'b0;
            total++;
            if (irq !== (m_mode == 1)) begin
                bad++;
                $display("FAIL rand_irq n=%0d got=%b exp=%b", n, irq, m_mode == 1);
            end
            addr = amap[$urandom_range(0, 4)];
            e = m_read(addr);
            bus_read(addr, d);
            total++;
            if (d !== e) begin
                bad++;
                $display("FAIL rand_read n=%0d got=%h exp=%h", n, d, e);
            end
            if (n % 50 == 0) begin
                addr = A_PEND;
                #1;
                total++;
                if (rdata !== 32'h0) begin
                    bad++;
                    $display("FAIL rand_nord got=%h exp=0", rdata);
                end
                addr = 32'h0;
            end
        end
        irq_ack = 1'b0;
        kernel = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [31:0] regs [4];
        bit          seen;
        regs = '{A_IE, A_PEND, A_CAUSE, A_CTRL};
        kernel = 1'b0;
        irq_ack = 1'b0;
        src = 4'h0;
        bus_write(A_IE, 32'hF);
        bus_write(A_CTRL, 32'h1);
        repeat (LAT + 3) tick();
        src = 4'b0100;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if (irq === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL mid_irq_timeout got=%b exp=1", irq);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL mid_irq_drop got=%b exp=0", irq);
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(regs[i], d);
            total++;
            if (d !== 32'h0) begin
                bad++;
                $display("FAIL mid_reg%0d got=%h exp=0", i, d);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (LAT + 4) tick();
        bus_read(A_PEND, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL mid_release_src got=%h exp=0", d);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_priority();
        test_service_return();
        test_w1c_in_req();
        test_set_wins();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-003 The block SHALL have port src, input, 4, interrupt source lines; src[0] is highest priority.
REQ-004 The block SHALL have port kernel, input, 1, CPU supervisor bit (PC[31]); 1 = kernel mode.
REQ-005 The block SHALL have port irq_ack, input, 1, CPU took the interrupt redirect this cycle.
REQ-006 The block SHALL have ports addr (input, 32), wdata (input, 32), rd (input, 1) and wr (input, 1), forming the peripheral bus.
REQ-007 The block SHALL have port rdata, output, 32, combinational read data.
REQ-008 The block SHALL have port irq, output, 1, interrupt request to the CPU control unit.

Function
REQ-009 The register map SHALL be:
- 0x40000030 IE[3:0], RW.
- 0x40000034 PEND[3:0]: read; write-1-to-clear.
- 0x40000038 CAUSE {valid, id[1:0]}: RO.
- 0x4000003C CTRL bit0 = GIE, RW.
REQ-010 Writes SHALL take effect on the clk edge where wr=1 and addr matches; all other addresses are ignored.
REQ-011 rdata SHALL equal the zero-extended addressed register when rd=1 and addr matches, else 32'h0.
REQ-012 Each src bit SHALL be registered each cycle; a 0->1 transition versus the prior sample SHALL set the matching PEND bit on that edge.
REQ-013 If a set and a W1C of the same PEND bit occur in one cycle, the set SHALL win.
REQ-014 FSM states: IDLE, REQ, SERVICE.
REQ-015 In IDLE: irq=0; the FSM SHALL move to REQ when GIE=1, |(PEND&IE)=1 and kernel=0.
REQ-016 In REQ: irq=1 (registered state decode, no combinational path from src).
REQ-017 In REQ with irq_ack=1, the FSM SHALL:
- latch the lowest set index of PEND&IE (pre-write value) into CAUSE.id;
- set CAUSE.valid;
- clear that PEND bit;
- move to SERVICE.
REQ-018 In REQ with irq_ack=0 and (PEND&IE)=0 or GIE=0, the FSM SHALL return to IDLE with no CAUSE change.
REQ-019 In SERVICE: irq=0; the FSM SHALL move to IDLE on the first cycle kernel=0 (handler returned) and clear CAUSE.valid; new edges keep accumulating in PEND.
REQ-020 irq_ack outside REQ SHALL be ignored.
REQ-021 Latency: a src edge sampled at edge k SHALL give PEND set after k, REQ (irq=1) after k+1, provided enable conditions already hold.

Reset
REQ-022 While reset=0, the following SHALL hold asynchronously, with rdata still following REQ-011:
- IE=0, PEND=0, GIE=0, CAUSE=0;
- src sample registers=0;
- FSM=IDLE, irq=0.
REQ-023 Reset asserted mid-REQ or mid-SERVICE SHALL drop irq immediately and discard pending state.
REQ-024 After release, a src line already high SHALL NOT register an edge.

Configuration
REQ-025 With IRQ_CTRL_SYNC_EN defined, each src bit SHALL pass a two-flop synchronizer (reset 0) before edge detection, adding exactly 2 cycles to REQ-021 latency.
REQ-026 Without IRQ_CTRL_SYNC_EN, src SHALL feed edge detection directly with REQ-021 latency.

Verification
REQ-027 The bench SHALL cover: IE=4'hF, GIE=1, kernel=0; pulse src[2] -> PEND=4'b0100 next edge, irq=1 one edge later; ack -> CAUSE=3'b110, PEND=0, irq=0.
REQ-028 The bench SHALL cover: src[3] and src[1] rise together, ack -> CAUSE.id=1, PEND=4'b1000.
REQ-029 The bench SHALL cover: in SERVICE drop kernel to 0 -> IDLE, then irq=1 one edge later for the remaining src[3] -> CAUSE.id=3 on ack.
REQ-030 The bench SHALL cover: in REQ write 0x40000034=4'hF with no new edges -> IDLE next edge, irq=0, CAUSE unchanged.
REQ-031 The bench SHALL cover: W1C of bit0 in the same cycle as a src[0] edge -> PEND[0]=1; kernel=1 with pending enabled -> irq stays 0.
REQ-032 The bench SHALL cover: reset=0 while irq=1 -> irq=0 and all registers read 0 immediately; with IRQ_CTRL_SYNC_EN, the REQ-027 irq rise is 2 cycles later.
